mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the E stage of the five-stage pipeline, owning the HI and LO registers. It executes mult/multu/div/divu as multi-cycle operations and mthi/mtlo as single-cycle writes. It feeds mfhi/mflo reads into the E result path. It exports a Busy flag that the hazard/stall logic consumes to hold any multiply/divide-class instruction in D while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (≥1)
- DIV_CYCLES, 10, Busy duration for div/divu (≥1)

Ports:
- clk  in  1  clock; single clock domain, rising-edge
- reset  in  1  synchronous, active-high
- Start  in  1  E-stage instruction is mult/multu/div/divu; one-cycle pulse per instruction
- MDUOp  in  4  operation code (`MDU_*` constants)
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- Busy  out  1  operation in flight
- Out  out  32  mfhi → HI, mflo → LO, otherwise 0; combinational from HI/LO

## Operation
- State: HI[31:0], LO[31:0], cnt (wide enough for max(MULT_CYCLES, DIV_CYCLES)), pending HI/LO result registers.
- Busy = (cnt != 0); purely registered, does not depend on Start.
- Idle (cnt==0) with Start at an edge:
  - compute the result from A/B and latch it into the pending registers
  - cnt <= MULT_CYCLES or DIV_CYCLES
- Busy (cnt>1) at an edge: cnt <= cnt-1.
- cnt==1 at an edge: HI/LO <= pending, cnt <= 0.
- Start while Busy: ignored. The stall logic must prevent this by stalling D when D is multiply/divide-class and (Start | Busy).
- mthi/mtlo (MDUOp, Start=0): HI or LO <= A at the edge when idle; ignored when Busy.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}
  - multu: unsigned 32×32→64, {HI,LO}
  - div/divu: LO=quotient, HI=remainder, truncation toward zero; remainder takes the sign of the dividend
  - signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0
- Divide by zero (B==0): the operation still runs its full DIV_CYCLES with Busy; HI/LO keep their prior values at completion.
- Reset (any time, including mid-operation): HI=0, LO=0, cnt=0, pending=0, Busy=0. An in-flight result is discarded.

## Timing
- Start sampled at edge T → Busy high for cycles T+1 … T+N (N = cycle parameter) and low at T+N+1.
- New HI/LO are visible on Out in the first cycle Busy is low.
- mthi/mtlo at edge T → Out reflects the new value from cycle T+1.
- Out is combinational from registered HI/LO: zero latency for mfhi/mflo, with no bypass from pending.
- Back-to-back: a Start at the edge where cnt goes 1→0 is ignored, because that cycle is still Busy. The next Start is accepted at the following edge.

## Structure
- def.v holds the `MDU_*` opcode constants: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, NONE.
- The control decoder gains `md` (mult/div class) and `mdu_use` (any HI/LO instruction) outputs for the stall logic; these live in the control module, not here.
- No sub-module: the countdown FSM and datapath fit inline. Product and quotient use native `*` `/` `%` on signed/unsigned casts.

## Test plan
- Reset, then mult A=0xFFFFFFFF, B=2 → Busy for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. The same inputs with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7, B=2 → Busy for 10 cycles; LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu of 7/2 → LO=3, HI=1.
- Divide by zero after mthi 0x1234 / mtlo 0x5678 → Busy for 10 cycles; HI/LO remain 0x1234/0x5678.
- Start at cnt==3, and mtlo with A=0xAAAA during Busy → both ignored; the final HI/LO equal the first operation's result.
- Reset asserted at cnt==2 of a mult → next cycle Busy=0, HI=LO=0, and the result is never committed.
- mtlo 0xDEAD, then mflo the next cycle → Out=0xDEAD. MDUOp=NONE → Out=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Opcode constants shared by the multiply/divide unit and its users.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: results are computed at Start, held in
// pending registers, and committed to HI/LO when the busy countdown expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Signed divide returning {remainder, quotient}; the one overflowing case
    // and a zero divisor are pinned so the native operators never see them.
    function automatic logic [63:0] div_signed(input logic signed [31:0] n,
                                               input logic signed [31:0] d);
        logic signed [31:0] q;
        logic signed [31:0] r;
        q = '0;
        r = '0;
        if (n == 32'sh80000000 && d == -32'sd1) begin
            q = n;
        end else if (d != 32'sd0) begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] n,
                                                 input logic [31:0] d);
        logic [31:0] q;
        logic [31:0] r;
        q = '0;
        r = '0;
        if (d != 32'd0) begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        hi, hi_nxt, lo, lo_nxt;
    logic [31:0]        pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
    logic               pend_ok, pend_ok_nxt;

    logic signed [63:0] a_ext, b_ext, prod_s;
    logic [63:0]        prod_u, quo_s, quo_u;

    assign a_ext  = {{32{A[31]}}, A};
    assign b_ext  = {{32{B[31]}}, B};
    assign prod_s = a_ext * b_ext;
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign quo_s  = div_signed(A, B);
    assign quo_u  = div_unsigned(A, B);

    always_comb begin
        cnt_nxt     = cnt;
        hi_nxt      = hi;
        lo_nxt      = lo;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_ok_nxt = pend_ok;
        if (cnt == '0) begin
            if (Start) begin
                case (MDUOp)
                    MDU_MULT: begin
                        {pend_hi_nxt, pend_lo_nxt} = prod_s;
                        pend_ok_nxt = 1'b1;
                        cnt_nxt     = CNT_W'(MULT_CYCLES);
                    end
                    MDU_MULTU: begin
                        {pend_hi_nxt, pend_lo_nxt} = prod_u;
                        pend_ok_nxt = 1'b1;
                        cnt_nxt     = CNT_W'(MULT_CYCLES);
                    end
                    MDU_DIV: begin
                        {pend_hi_nxt, pend_lo_nxt} = quo_s;
                        pend_ok_nxt = (B != 32'd0);
                        cnt_nxt     = CNT_W'(DIV_CYCLES);
                    end
                    MDU_DIVU: begin
                        {pend_hi_nxt, pend_lo_nxt} = quo_u;
                        pend_ok_nxt = (B != 32'd0);
                        cnt_nxt     = CNT_W'(DIV_CYCLES);
                    end
                    default: ;
                endcase
            end else if (MDUOp == MDU_MTHI) begin
                hi_nxt = A;
            end else if (MDUOp == MDU_MTLO) begin
                lo_nxt = A;
            end
        end else if (cnt == CNT_W'(1)) begin
            // Divide-by-zero still runs the full countdown but commits nothing.
            if (pend_ok) begin
                hi_nxt = pend_hi;
                lo_nxt = pend_lo;
            end
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_ok <= pend_ok_nxt;
        end
    end

    assign Busy = (cnt != '0);

    always_comb begin
        Out = '0;
        if (MDUOp == MDU_MFHI) Out = hi;
        else if (MDUOp == MDU_MFLO) Out = lo;
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, arithmetic results, ignored requests,
// reset abort and HI/LO moves, with hand-computed expectations.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] Out;

    int passed = 0;
    int total  = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
        .A(A), .B(B), .Busy(Busy), .Out(Out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp = op; A = a; B = b; Start = 1'b1;
        step();
        Start = 1'b0; MDUOp = MDU_NONE;
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] a);
        MDUOp = op; A = a; Start = 1'b0;
        step();
        MDUOp = MDU_NONE;
    endtask

    task automatic busy_cycles(output int n);
        n = 0;
        while (Busy && n < 50) begin
            n++;
            step();
        end
    endtask

    task automatic read(input logic [3:0] op, output logic [31:0] v);
        MDUOp = op;
        #1;
        v = Out;
        MDUOp = MDU_NONE;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; Start = 1'b0; MDUOp = MDU_NONE; A = '0; B = '0;
        step(); step();
        reset = 1'b0;
        total++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", Busy); else passed++;
        read(MDU_MFHI, v);
        total++; if (v !== 32'h0) $display("FAIL reset_hi got=%h exp=0", v); else passed++;
        read(MDU_MFLO, v);
        total++; if (v !== 32'h0) $display("FAIL reset_lo got=%h exp=0", v); else passed++;
    endtask

    task automatic test_arith(input string name, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b, input int exp_n,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        logic [31:0] v;
        issue(op, a, b);
        busy_cycles(n);
        total++; if (n != exp_n) $display("FAIL %s_busy got=%0d exp=%0d", name, n, exp_n); else passed++;
        read(MDU_MFHI, v);
        total++; if (v !== exp_hi) $display("FAIL %s_hi got=%h exp=%h", name, v, exp_hi); else passed++;
        read(MDU_MFLO, v);
        total++; if (v !== exp_lo) $display("FAIL %s_lo got=%h exp=%h", name, v, exp_lo); else passed++;
    endtask

    task automatic test_div_zero();
        move(MDU_MTHI, 32'h1234);
        move(MDU_MTLO, 32'h5678);
        test_arith("divzero", MDU_DIV, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);
    endtask

    task automatic test_ignore();
        logic [31:0] v;
        issue(MDU_MULT, 32'd3, 32'd5);           // cnt=5
        step(); step();                          // cnt=3
        MDUOp = MDU_DIV; A = 32'd100; B = 32'd7; Start = 1'b1;
        step();                                  // cnt=2
        Start = 1'b0; MDUOp = MDU_MTLO; A = 32'hAAAA;
        step();                                  // cnt=1
        MDUOp = MDU_NONE;
        total++; if (Busy !== 1'b1) $display("FAIL ignore_busy_mid got=%b exp=1", Busy); else passed++;
        step();                                  // cnt=0
        step();
        total++; if (Busy !== 1'b0) $display("FAIL ignore_busy_end got=%b exp=0", Busy); else passed++;
        read(MDU_MFHI, v);
        total++; if (v !== 32'h0) $display("FAIL ignore_hi got=%h exp=0", v); else passed++;
        read(MDU_MFLO, v);
        total++; if (v !== 32'd15) $display("FAIL ignore_lo got=%h exp=%h", v, 32'd15); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        issue(MDU_MULT, 32'd2, 32'd3);           // cnt=5
        step(); step(); step();                  // cnt=2
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (Busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", Busy); else passed++;
        read(MDU_MFHI, v);
        total++; if (v !== 32'h0) $display("FAIL rstmid_hi got=%h exp=0", v); else passed++;
        read(MDU_MFLO, v);
        total++; if (v !== 32'h0) $display("FAIL rstmid_lo got=%h exp=0", v); else passed++;
        for (int i = 0; i < 6; i++) step();
        total++; if (Busy !== 1'b0) $display("FAIL rstmid_busy_late got=%b exp=0", Busy); else passed++;
        read(MDU_MFLO, v);
        total++; if (v !== 32'h0) $display("FAIL rstmid_lo_late got=%h exp=0", v); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] v;
        issue(MDU_MULT, 32'd4, 32'd4);           // cnt=5
        step(); step(); step(); step();          // cnt=1
        MDUOp = MDU_MULTU; A = 32'd2; B = 32'd2; Start = 1'b1;
        step();                                  // 1->0, Start ignored
        total++; if (Busy !== 1'b0) $display("FAIL b2b_ignored got=%b exp=0", Busy); else passed++;
        read(MDU_MFLO, v);
        MDUOp = MDU_MULTU; Start = 1'b1;
        total++; if (v !== 32'd16) $display("FAIL b2b_first_lo got=%h exp=%h", v, 32'd16); else passed++;
        step();                                  // accepted
        Start = 1'b0; MDUOp = MDU_NONE;
        busy_cycles(n);
        total++; if (n != 5) $display("FAIL b2b_busy got=%0d exp=5", n); else passed++;
        read(MDU_MFLO, v);
        total++; if (v !== 32'd4) $display("FAIL b2b_second_lo got=%h exp=%h", v, 32'd4); else passed++;
    endtask

    task automatic test_mflo();
        logic [31:0] v;
        move(MDU_MTLO, 32'hDEAD);
        read(MDU_MFLO, v);
        total++; if (v !== 32'hDEAD) $display("FAIL mflo got=%h exp=0000dead", v); else passed++;
        MDUOp = MDU_NONE;
        #1;
        total++; if (Out !== 32'h0) $display("FAIL none_out got=%h exp=0", Out); else passed++;
    endtask

    initial begin
        test_reset();
        test_arith("mult",  MDU_MULT,  32'hFFFFFFFF, 32'd2, 5,  32'hFFFFFFFF, 32'hFFFFFFFE);
        test_arith("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 5,  32'h00000001, 32'hFFFFFFFE);
        test_arith("div",   MDU_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_arith("divu",  MDU_DIVU,  32'd7,        32'd2, 10, 32'h00000001, 32'h00000003);
        test_arith("divovf", MDU_DIV,  32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
        test_div_zero();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_mflo();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
